// File: rtl/unidad_mul_div.sv
// Iterative RV32M multiply/divide: 32-step shift-add multiply or restoring divide on magnitudes.
// Latency: 34 cycles Start->Done (1 for divide special cases); Start is ignored while Busy.
module unidad_mul_div #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Start,
  input  logic [2:0]        Funct3,
  input  logic [WIDTH-1:0]  Op_A,
  input  logic [WIDTH-1:0]  Op_B,
  input  logic [ADDR_W-1:0] Add_Dest_In,
  output logic              Busy,
  output logic              Done,
  output logic [WIDTH-1:0]  Result,
  output logic [ADDR_W-1:0] Add_Dest,
  output logic              Write_En
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [2:0]          r_f3;
  logic [WIDTH-1:0]    r_hi, r_lo, r_md, r_result;
  logic [ADDR_W-1:0]   r_add_dest;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_neg, r_sa;

  logic                w_signed_a, w_signed_b, w_neg_a, w_neg_b, w_special;
  logic [WIDTH-1:0]    w_mag_a, w_mag_b, w_spec_res;
  logic [WIDTH:0]      w_sum, w_trial;
  logic                w_qbit;
  logic [WIDTH-1:0]    w_rem_nxt, w_q_nxt, w_quot, w_rem, w_fix_res;
  logic [2*WIDTH-1:0]  w_prod, w_prod_s;

  assign w_signed_a = Funct3[2] ? ~Funct3[0] : (Funct3 == 3'd1 || Funct3 == 3'd2);
  assign w_signed_b = Funct3[2] ? ~Funct3[0] : (Funct3 == 3'd1);
  assign w_neg_a    = w_signed_a & Op_A[WIDTH-1];
  assign w_neg_b    = w_signed_b & Op_B[WIDTH-1];
  assign w_mag_a    = w_neg_a ? -Op_A : Op_A;
  assign w_mag_b    = w_neg_b ? -Op_B : Op_B;

  // Divide by zero and signed overflow bypass the iteration entirely
  assign w_special  = Funct3[2] && ((Op_B == '0) ||
                      (!Funct3[0] && Op_A == MIN_NEG && Op_B == '1));
  assign w_spec_res = (Op_B == '0) ? (Funct3[1] ? Op_A : '1)
                                   : (Funct3[1] ? '0 : MIN_NEG);

  assign w_sum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_md} : '0);
  assign w_trial   = {r_hi, r_lo[WIDTH-1]} - {1'b0, r_md};
  assign w_qbit    = ~w_trial[WIDTH];
  assign w_rem_nxt = w_qbit ? w_trial[WIDTH-1:0] : {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
  assign w_q_nxt   = {r_lo[WIDTH-2:0], w_qbit};

  assign w_prod    = {r_hi, r_lo};
  assign w_prod_s  = r_neg ? -w_prod : w_prod;
  assign w_quot    = r_neg ? -r_lo : r_lo;
  assign w_rem     = r_sa ? -r_hi : r_hi;
  assign w_fix_res = r_f3[2] ? (r_f3[1] ? w_rem : w_quot)
                             : ((r_f3 == 3'd0) ? w_prod_s[WIDTH-1:0] : w_prod_s[2*WIDTH-1:WIDTH]);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (Start) w_state_nxt = w_special ? DONE : CALC;
      CALC:    if (r_cnt == CNT_W'(WIDTH-1)) w_state_nxt = FIX;
      FIX:     w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_f3       <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_md       <= '0;
      r_cnt      <= '0;
      r_neg      <= 1'b0;
      r_sa       <= 1'b0;
      r_result   <= '0;
      r_add_dest <= '0;
    end else begin
      case (r_state)
        IDLE: if (Start) begin
          r_f3       <= Funct3;
          r_add_dest <= Add_Dest_In;
          r_cnt      <= '0;
          r_hi       <= '0;
          r_lo       <= w_mag_a;
          r_md       <= w_mag_b;
          r_neg      <= w_neg_a ^ w_neg_b;
          r_sa       <= w_neg_a;
          if (w_special) r_result <= w_spec_res;
        end
        CALC: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_f3[2]) {r_hi, r_lo} <= {w_rem_nxt, w_q_nxt};
          else         {r_hi, r_lo} <= {w_sum, r_lo[WIDTH-1:1]};
        end
        FIX:     r_result <= w_fix_res;
        default: ;
      endcase
    end
  end

  assign Busy     = (r_state != IDLE);
  assign Done     = (r_state == DONE);
  assign Result   = r_result;
  assign Add_Dest = r_add_dest;
  assign Write_En = Done & (r_add_dest != '0);

endmodule
